// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and DEPTH-entry prefetch FIFO feeding decode.
// Define FETCH_JUMP_PREDECODE_EN to follow j/jal targets at fetch time (needs WIDTH == 32).
module fetch_queue #(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [WIDTH-1:0]         pcF,
   input  logic [WIDTH-1:0]         instrF,
   input  logic                     stallD,
   input  logic                     redirectD,
   input  logic [WIDTH-1:0]         redirect_pcD,
   output logic [WIDTH-1:0]         instrD,
   output logic [WIDTH-1:0]         pcplus4D,
   output logic                     validD,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_instr [DEPTH];
   logic [WIDTH-1:0] r_pc4   [DEPTH];
   logic [AW-1:0]    r_rd, r_wr;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_pc;
   logic             w_pop, w_push;
   logic [WIDTH-1:0] w_pc4, w_next_pc;

   assign w_pc4 = r_pc + WIDTH'(4);
`ifdef FETCH_JUMP_PREDECODE_EN
   if (WIDTH != 32) begin : g_width_chk
      $error("fetch_queue: FETCH_JUMP_PREDECODE_EN requires WIDTH == 32");
   end
   logic w_jump;
   // j = 000010, jal = 000011: both share the top five opcode bits
   assign w_jump    = instrF[31:27] == 5'b00001;
   assign w_next_pc = w_jump ? {w_pc4[31:28], instrF[25:0], 2'b00} : w_pc4;
`else
   assign w_next_pc = w_pc4;
`endif

   assign validD   = r_count != '0;
   assign full     = r_count == (AW+1)'(DEPTH);
   assign count    = r_count;
   assign pcF      = r_pc;
   assign instrD   = validD ? r_instr[r_rd] : '0;
   assign pcplus4D = validD ? r_pc4[r_rd] : '0;
   assign w_pop    = validD & ~stallD & ~redirectD;
   assign w_push   = ~redirectD & (~full | w_pop);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc    <= RESET_PC;
         r_count <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
      end else if (redirectD) begin
         r_pc    <= redirect_pcD;
         r_count <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
      end else begin
         if (w_push) begin
            r_pc <= w_next_pc;
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset && w_push) begin
         r_instr[r_wr] <= instrF;
         r_pc4[r_wr]   <= w_pc4;
      end
   end
endmodule
